uart_rx_timing: RTL and testbench

UART_RX_TIMING -- requirements
Module: uart_rx_timing

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_timing.sv | 133 +++++++++++++
 tb/tb_uart_rx_timing.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART receive timing package: clock/baud defaults,
// bit-period helpers and the timing FSM state type.
package uart_pkg;

   localparam int unsigned DEF_CLK_HZ = 100_000_000;
   localparam int unsigned DEF_BAUD   = 115_200;

   // start + 8 data + stop
   localparam logic [3:0] FRAME_TICKS = 4'd10;

   typedef enum logic [1:0] {
      IDLE,
      START,
      BITS
   } state_t;

   function automatic int unsigned clks_per_bit(
      input int unsigned clk_hz,
      input int unsigned baud
   );
      return clk_hz / baud;
   endfunction

   function automatic int unsigned half_bit(
      input int unsigned clk_hz,
      input int unsigned baud
   );
      return clks_per_bit(clk_hz, baud) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, 1 bit, reset to RST_VAL.
// Ports: clk, reset_n (async low), d (async in), q (synced).
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_timing.sv
// UART RX bit timing: syncs the pin, finds the start edge,
// pulses center_tick at each of the 10 bit centres of a frame.
// Ports: clk, reset_n, rx_async, phase_arm -> rx_sync_out,
//        center_tick, busy, false_start.
module uart_rx_timing
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = DEF_CLK_HZ,
   parameter int unsigned BAUD   = DEF_BAUD
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rx_async,
   input  logic phase_arm,
   output logic rx_sync_out,
   output logic center_tick,
   output logic busy,
   output logic false_start
);

   localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned HALF = half_bit(CLK_HZ, BAUD);
   localparam int unsigned CW   = $clog2(CPB);

   localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [3:0]    LAST_BIT = FRAME_TICKS - 4'd1;

   generate
      if (CPB < 4) begin : g_cpb_check
         $error("uart_rx_timing: CLK_HZ/BAUD must be >= 4");
      end
   endgenerate

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    bit_cnt, bit_n;
   logic          tick_n, fs_n;
   logic          rx_prev;
   logic [1:0]    fill;
   logic          seen_high;
   logic          fall;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (rx_async),
      .q      (rx_sync_out)
   );

   // The synchronizer reset value is not a real sample of
   // the pin; only accept edges once a true high was seen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_prev   <= 1'b1;
         fill      <= 2'd0;
         seen_high <= 1'b0;
      end else begin
         rx_prev <= rx_sync_out;
         if (fill != 2'd2)
            fill <= fill + 2'd1;
         if (fill == 2'd2 && rx_sync_out)
            seen_high <= 1'b1;
      end
   end

   assign fall = rx_prev & ~rx_sync_out & seen_high;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_cnt;
      tick_n  = 1'b0;
      fs_n    = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall && phase_arm) begin
               state_n = START;
               cnt_n   = '0;
               bit_n   = 4'd0;
            end
         end
         START: begin
            if (cnt == HALF_END) begin
               cnt_n = '0;
               if (!rx_sync_out) begin
                  tick_n  = 1'b1;
                  bit_n   = 4'd1;
                  state_n = BITS;
               end else begin
                  fs_n    = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BITS: begin
            if (cnt == BIT_END) begin
               cnt_n  = '0;
               tick_n = 1'b1;
               bit_n  = bit_cnt + 4'd1;
               if (bit_cnt == LAST_BIT)
                  state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= 4'd0;
         center_tick <= 1'b0;
         false_start <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         bit_cnt     <= bit_n;
         center_tick <= tick_n;
         false_start <= fs_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_timing.sv
// Directed self-checking bench for uart_rx_timing
// at default CLK_HZ/BAUD (868 clocks per bit).
module tb_uart_rx_timing;

   localparam int CPB  = 868;
   localparam int HALF = 434;

   logic clk = 1'b0;
   logic reset_n;
   logic rx_async;
   logic phase_arm;
   logic rx_sync_out;
   logic center_tick;
   logic busy;
   logic false_start;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int tick_q[$];
   int pin_q[$];
   int fs_cnt = 0;
   int both_cnt = 0;
   bit busy_seen = 1'b0;
   bit busy_at_tick = 1'b0;
   bit tx_done = 1'b0;

   uart_rx_timing dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_async   (rx_async),
      .phase_arm  (phase_arm),
      .rx_sync_out(rx_sync_out),
      .center_tick(center_tick),
      .busy       (busy),
      .false_start(false_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         if (center_tick && false_start)
            both_cnt++;
         if (center_tick) begin
            tick_q.push_back(cyc);
            busy_at_tick = busy;
         end
         if (false_start)
            fs_cnt++;
         if (busy)
            busy_seen = 1'b1;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      tick_q.delete();
      pin_q.delete();
      fs_cnt    = 0;
      busy_seen = 1'b0;
   endtask

   // pin_q holds the first clock edge that samples the start bit
   task automatic send_byte(input logic [7:0] b,
                            input logic stop_v,
                            input int stop_bits);
      rx_async = 1'b0;
      pin_q.push_back(cyc + 1);
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_async = b[i];
         wait_cyc(CPB);
      end
      rx_async = stop_v;
      wait_cyc(CPB * stop_bits);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      rx_async  = 1'b0;
      phase_arm = 1'b1;
      wait_cyc(5);
      checks++;
      if (rx_sync_out !== 1'b1) begin
         errors++;
         $display("FAIL rst_sync: got %b want 1", rx_sync_out);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got %b want 0", busy);
      end
      checks++;
      if (center_tick !== 1'b0) begin
         errors++;
         $display("FAIL rst_tick: got %b want 0", center_tick);
      end
      checks++;
      if (false_start !== 1'b0) begin
         errors++;
         $display("FAIL rst_fs: got %b want 0", false_start);
      end
      reset_n = 1'b1;
      clear_mon();
      wait_cyc(1000);
      checks++;
      if (tick_q.size() !== 0) begin
         errors++;
         $display("FAIL low_rel_ticks: got %0d want 0", tick_q.size());
      end
      checks++;
      if (busy_seen !== 1'b0) begin
         errors++;
         $display("FAIL low_rel_busy: got %b want 0", busy_seen);
      end
      rx_async = 1'b1;
      wait_cyc(20);
   endtask

   task automatic test_good_frame();
      clear_mon();
      send_byte(8'h55, 1'b1, 1);
      wait_cyc(50);
      checks++;
      if (tick_q.size() !== 10) begin
         errors++;
         $display("FAIL good_ticks: got %0d want 10", tick_q.size());
      end
      if (tick_q.size() > 0) begin
         checks++;
         if (tick_q[0] - pin_q[0] !== HALF + 2) begin
            errors++;
            $display("FAIL good_first: got %0d want %0d",
                     tick_q[0] - pin_q[0], HALF + 2);
         end
      end
      for (int i = 1; i < 10 && i < tick_q.size(); i++) begin
         checks++;
         if (tick_q[i] - tick_q[i-1] !== CPB) begin
            errors++;
            $display("FAIL good_space[%0d]: got %0d want %0d",
                     i, tick_q[i] - tick_q[i-1], CPB);
         end
      end
      checks++;
      if (busy_at_tick !== 1'b0) begin
         errors++;
         $display("FAIL good_busy_last: got %b want 0", busy_at_tick);
      end
      checks++;
      if (busy_seen !== 1'b1) begin
         errors++;
         $display("FAIL good_busy_mid: got %b want 1", busy_seen);
      end
      checks++;
      if (fs_cnt !== 0) begin
         errors++;
         $display("FAIL good_fs: got %0d want 0", fs_cnt);
      end
   endtask

   task automatic test_false_start();
      clear_mon();
      rx_async = 1'b0;
      wait_cyc(100);
      rx_async = 1'b1;
      wait_cyc(1000);
      checks++;
      if (fs_cnt !== 1) begin
         errors++;
         $display("FAIL glitch_fs: got %0d want 1", fs_cnt);
      end
      checks++;
      if (tick_q.size() !== 0) begin
         errors++;
         $display("FAIL glitch_ticks: got %0d want 0", tick_q.size());
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_disarmed();
      clear_mon();
      phase_arm = 1'b0;
      rx_async  = 1'b0;
      wait_cyc(1000);
      rx_async = 1'b1;
      wait_cyc(50);
      phase_arm = 1'b1;
      wait_cyc(10);
      checks++;
      if (tick_q.size() !== 0) begin
         errors++;
         $display("FAIL disarm_ticks: got %0d want 0", tick_q.size());
      end
      checks++;
      if (busy_seen !== 1'b0) begin
         errors++;
         $display("FAIL disarm_busy: got %b want 0", busy_seen);
      end
   endtask

   task automatic test_low_stop();
      clear_mon();
      send_byte(8'hC1, 1'b0, 2);
      checks++;
      if (tick_q.size() !== 10) begin
         errors++;
         $display("FAIL lstop_ticks1: got %0d want 10", tick_q.size());
      end
      rx_async = 1'b1;
      wait_cyc(2 * CPB);
      checks++;
      if (tick_q.size() !== 10) begin
         errors++;
         $display("FAIL lstop_hold: got %0d want 10", tick_q.size());
      end
      send_byte(8'h3A, 1'b1, 1);
      wait_cyc(50);
      checks++;
      if (tick_q.size() !== 20) begin
         errors++;
         $display("FAIL lstop_ticks2: got %0d want 20", tick_q.size());
      end
      if (tick_q.size() > 10) begin
         checks++;
         if (tick_q[10] - pin_q[1] !== HALF + 2) begin
            errors++;
            $display("FAIL lstop_first2: got %0d want %0d",
                     tick_q[10] - pin_q[1], HALF + 2);
         end
      end
      for (int i = 1; i < 20 && i < tick_q.size(); i++) begin
         if (i != 10) begin
            checks++;
            if (tick_q[i] - tick_q[i-1] !== CPB) begin
               errors++;
               $display("FAIL lstop_space[%0d]: got %0d want %0d",
                        i, tick_q[i] - tick_q[i-1], CPB);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      tx_done = 1'b0;
      fork
         begin
            send_byte(8'hF8, 1'b1, 1);
            tx_done = 1'b1;
         end
      join_none
      for (int i = 0; i < 6 * CPB && tick_q.size() < 4; i++)
         wait_cyc(1);
      checks++;
      if (tick_q.size() < 4) begin
         errors++;
         $display("FAIL rmid_wait4: got %0d want 4", tick_q.size());
      end
      reset_n = 1'b0;
      wait_cyc(1);
      checks++;
      if (rx_sync_out !== 1'b1) begin
         errors++;
         $display("FAIL rmid_sync: got %b want 1", rx_sync_out);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rmid_busy: got %b want 0", busy);
      end
      wait_cyc(20);
      reset_n = 1'b1;
      for (int i = 0; i < 12 * CPB && !tx_done; i++)
         wait_cyc(1);
      checks++;
      if (tx_done !== 1'b1) begin
         errors++;
         $display("FAIL rmid_txdone: got %b want 1", tx_done);
      end
      wait_cyc(CPB);
      checks++;
      if (tick_q.size() !== 4) begin
         errors++;
         $display("FAIL rmid_after: got %0d want 4", tick_q.size());
      end
      clear_mon();
      send_byte(8'hA5, 1'b1, 1);
      wait_cyc(50);
      checks++;
      if (tick_q.size() !== 10) begin
         errors++;
         $display("FAIL rmid_next: got %0d want 10", tick_q.size());
      end
      if (tick_q.size() > 0) begin
         checks++;
         if (tick_q[0] - pin_q[0] !== HALF + 2) begin
            errors++;
            $display("FAIL rmid_first: got %0d want %0d",
                     tick_q[0] - pin_q[0], HALF + 2);
         end
      end
      for (int i = 1; i < 10 && i < tick_q.size(); i++) begin
         checks++;
         if (tick_q[i] - tick_q[i-1] !== CPB) begin
            errors++;
            $display("FAIL rmid_space[%0d]: got %0d want %0d",
                     i, tick_q[i] - tick_q[i-1], CPB);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_byte(8'h0F, 1'b1, 1);
      send_byte(8'hF0, 1'b1, 1);
      wait_cyc(50);
      checks++;
      if (tick_q.size() !== 20) begin
         errors++;
         $display("FAIL b2b_ticks: got %0d want 20", tick_q.size());
      end
      for (int f = 0; f < 2; f++) begin
         if (tick_q.size() > f * 10 && pin_q.size() > f) begin
            checks++;
            if (tick_q[f*10] - pin_q[f] !== HALF + 2) begin
               errors++;
               $display("FAIL b2b_first[%0d]: got %0d want %0d",
                        f, tick_q[f*10] - pin_q[f], HALF + 2);
            end
         end
      end
      for (int i = 1; i < 20 && i < tick_q.size(); i++) begin
         if (i != 10) begin
            checks++;
            if (tick_q[i] - tick_q[i-1] !== CPB) begin
               errors++;
               $display("FAIL b2b_space[%0d]: got %0d want %0d",
                        i, tick_q[i] - tick_q[i-1], CPB);
            end
         end
      end
      checks++;
      if (fs_cnt !== 0) begin
         errors++;
         $display("FAIL b2b_fs: got %0d want 0", fs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_false_start();
      test_disarmed();
      test_low_stop();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL tick_fs_overlap: got %0d want 0", both_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
